// File: rtl/seven_seg_digit_sequencer.sv
// Single-digit 7-segment sequencer: a BCD digit that counts up or down at a prescaled rate or
// single-steps while paused. Buttons are synchronised and debounced internally.
module seven_seg_digit_sequencer #(
    parameter int unsigned TICK_DIV        = 125_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 1_250_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_run,
    input  logic       btn_step,
    input  logic       dir_up,
    output logic [6:0] seg,
    output logic [3:0] digit,
    output logic       running,
    output logic       tick
);

    localparam int PRE_W = $clog2(TICK_DIV);
    localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);
    localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DEBOUNCE_CYCLES - 1);

    // The FSM state is visible on the running output.
    typedef enum logic {
        S_PAUSED  = 1'b0,
        S_RUNNING = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [PRE_W-1:0] presc_q, presc_d;
    logic [3:0]       digit_q, digit_d;
    logic [6:0]       seg_q, seg_d;
    logic             tick_q, tick_d;
    // Bit 0 = run button, bit 1 = step button, bit 2 = direction switch.
    logic [2:0]       sync1_q, sync1_d;
    logic [2:0]       sync2_q, sync2_d;
    logic [1:0]       db_level_q, db_level_d;
    logic [DB_W-1:0]  db_cnt_q [2];
    logic [DB_W-1:0]  db_cnt_d [2];
    logic [1:0]       press;
    logic             run_pulse, step_pulse, wrap, advance;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b1111110;
            4'd1:    decode = 7'b0110000;
            4'd2:    decode = 7'b1101101;
            4'd3:    decode = 7'b1111001;
            4'd4:    decode = 7'b0110011;
            4'd5:    decode = 7'b1011011;
            4'd6:    decode = 7'b1011111;
            4'd7:    decode = 7'b1110000;
            4'd8:    decode = 7'b1111111;
            4'd9:    decode = 7'b1111011;
            default: decode = 7'b1111110;
        endcase
    endfunction

    always_comb begin
        sync1_d    = {dir_up, btn_step, btn_run};
        sync2_d    = sync1_q;
        db_level_d = db_level_q;
        for (int i = 0; i < 2; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != db_level_q[i]) begin
                // Accept the new level only after DEBOUNCE_CYCLES consecutive differing cycles.
                if (db_cnt_q[i] == DB_MAX) begin
                    db_level_d[i] = ~db_level_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
        press      = db_level_d & ~db_level_q;
        run_pulse  = press[0];
        step_pulse = press[1];
    end

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        wrap    = 1'b0;
        advance = 1'b0;
        case (state_q)
            S_PAUSED: begin
                if (run_pulse) begin
                    state_d = S_RUNNING;
                    presc_d = '0;
                end else if (step_pulse) begin
                    advance = 1'b1;
                end
            end
            S_RUNNING: begin
                if (presc_q == PRE_MAX) begin
                    presc_d = '0;
                    wrap    = 1'b1;
                end else begin
                    presc_d = presc_q + 1'b1;
                end
                advance = wrap;
                // A run press on the wrap cycle still lets that tick's advance through.
                if (run_pulse) begin
                    state_d = S_PAUSED;
                    presc_d = '0;
                end
            end
            default: begin
                state_d = S_PAUSED;
                presc_d = '0;
            end
        endcase
    end

    always_comb begin
        digit_d = digit_q;
        if (digit_q > 4'd9) begin
            digit_d = 4'd0;
        end else if (advance) begin
            if (sync2_q[2]) begin
                digit_d = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
            end else begin
                digit_d = (digit_q == 4'd0) ? 4'd9 : digit_q - 4'd1;
            end
        end
        seg_d  = decode(digit_d);
        tick_d = wrap;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_PAUSED;
            presc_q     <= '0;
            digit_q     <= 4'd0;
            seg_q       <= 7'b1111110;
            tick_q      <= 1'b0;
            sync1_q     <= '0;
            sync2_q     <= '0;
            db_level_q  <= '0;
            db_cnt_q[0] <= '0;
            db_cnt_q[1] <= '0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            digit_q     <= digit_d;
            seg_q       <= seg_d;
            tick_q      <= tick_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            db_level_q  <= db_level_d;
            db_cnt_q[0] <= db_cnt_d[0];
            db_cnt_q[1] <= db_cnt_d[1];
        end
    end

    assign seg     = seg_q;
    assign digit   = digit_q;
    assign running = (state_q == S_RUNNING);
    assign tick    = tick_q;

endmodule
